// File: rtl/code_sec_pkg.sv
// code_sec_pkg: shared state encoding and MMIO map
// for the multi-region code-section controller.
package code_sec_pkg;

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      UPDATE = 2'd1,
      SEALED = 2'd2
   } state_t;

   localparam int unsigned IDX_CTRL  = 0;
   localparam int unsigned IDX_VADDR = 1;
   localparam int unsigned IDX_VSTAT = 2;
   localparam int unsigned IDX_TMR   = 3;
   localparam int unsigned IDX_BASE0 = 4;

   localparam int unsigned CTRL_UPD_SET = 16;
   localparam int unsigned CTRL_UPD_CLR = 17;
   localparam int unsigned CTRL_SEAL    = 18;

endpackage

// File: rtl/code_sec_region_match.sv
// code_sec_region_match: per-region window hit vector
// and lowest-index priority encoder.
module code_sec_region_match #(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 32
) (
   input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] i_base,
   input  logic [NUM_REGIONS-1:0][ADDR_W-1:0] i_limit,
   input  logic [ADDR_W-1:0]                  i_addr,
   output logic                               o_hit,
   output logic [3:0]                         o_idx
);

   logic [NUM_REGIONS-1:0] w_hit;

   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         w_hit[i] = (i_limit[i] >= i_base[i]) &&
                    (i_limit[i] != '0) &&
                    (i_addr >= i_base[i]) &&
                    (i_addr <= i_limit[i]);
      end
   end

   // scan downward so the lowest matching index wins
   always_comb begin
      o_idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (w_hit[i]) o_idx = 4'(i);
      end
   end

   assign o_hit = |w_hit;

endmodule

// File: rtl/code_sec_ctrl_mr.sv
// code_sec_ctrl_mr: multi-region code write guard.
// Optional update-window timeout: CODE_SEC_TIMEOUT_EN.
module code_sec_ctrl_mr
   import code_sec_pkg::*;
#(
   parameter int          NUM_REGIONS    = 4,
   parameter int          ADDR_W         = 32,
   parameter int          TIMEOUT_W      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 32'hFFFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   lock_i,
   input  logic                   wr_en,
   input  logic [5:0]             wr_idx,
   input  logic [31:0]            wr_data,
   input  logic [5:0]             rd_idx,
   output logic [31:0]            rd_data,
   input  logic                   chk_valid,
   input  logic [ADDR_W-1:0]      chk_addr,
   output logic                   chk_allow,
   output logic                   chk_deny,
   output logic                   update_en_o,
   output logic [NUM_REGIONS-1:0] wp_o,
   output logic                   viol_irq
);

   state_t                             r_state;
   logic [NUM_REGIONS-1:0]             r_wp;
   logic [NUM_REGIONS-1:0][ADDR_W-1:0] r_base;
   logic [NUM_REGIONS-1:0][ADDR_W-1:0] r_limit;
   logic                               r_vvalid;
   logic [ADDR_W-1:0]                  r_vaddr;
   logic [3:0]                         r_vreg;
   logic [TIMEOUT_W-1:0]               w_tmr;

   logic       w_ctrl_wr, w_vstat_wr;
   logic       w_seal, w_set, w_clr;
   logic       w_hit, w_allow, w_deny, w_vkeep;
   logic [3:0] w_ridx;
   logic [15:0] w_wp16;

   assign w_ctrl_wr  = wr_en && (wr_idx == 6'(IDX_CTRL));
   assign w_vstat_wr = wr_en && (wr_idx == 6'(IDX_VSTAT));
   assign w_seal = lock_i | (w_ctrl_wr & wr_data[CTRL_SEAL]);
   assign w_set  = w_ctrl_wr & wr_data[CTRL_UPD_SET];
   assign w_clr  = w_ctrl_wr & wr_data[CTRL_UPD_CLR];

`ifdef CODE_SEC_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_cnt;
   assign w_tmr = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= OPEN;
         r_cnt   <= '0;
      end else if (w_seal) begin
         r_state <= SEALED;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            OPEN: if (w_set && !w_clr) begin
               r_state <= UPDATE;
               r_cnt   <= TIMEOUT_W'(TIMEOUT_CYCLES);
            end
            UPDATE: if (w_clr) begin
               r_state <= OPEN;
               r_cnt   <= '0;
            end else if (w_set) begin
               r_cnt <= TIMEOUT_W'(TIMEOUT_CYCLES);
            end else if (r_cnt <= TIMEOUT_W'(1)) begin
               r_state <= OPEN;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
            default: r_state <= SEALED;
         endcase
      end
   end
`else
   logic w_unused_to;
   assign w_unused_to = ^TIMEOUT_W'(TIMEOUT_CYCLES);
   assign w_tmr = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= OPEN;
      end else if (w_seal) begin
         r_state <= SEALED;
      end else begin
         unique case (r_state)
            OPEN:    if (w_set && !w_clr) r_state <= UPDATE;
            UPDATE:  if (w_clr) r_state <= OPEN;
            default: r_state <= SEALED;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_base  <= '0;
         r_limit <= '0;
      end else begin
         if (w_ctrl_wr) r_wp <= r_wp | wr_data[NUM_REGIONS-1:0];
         if (wr_en && r_state == OPEN) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
               if (wr_idx == 6'(IDX_BASE0 + 2 * i))
                  r_base[i] <= ADDR_W'(wr_data);
               if (wr_idx == 6'(IDX_BASE0 + 2 * i + 1))
                  r_limit[i] <= ADDR_W'(wr_data);
            end
         end
      end
   end

   code_sec_region_match #(
      .NUM_REGIONS (NUM_REGIONS),
      .ADDR_W      (ADDR_W)
   ) u_match (
      .i_base  (r_base),
      .i_limit (r_limit),
      .i_addr  (chk_addr),
      .o_hit   (w_hit),
      .o_idx   (w_ridx)
   );

   assign w_wp16  = 16'(r_wp);
   assign w_allow = !w_hit ||
                    (r_state == UPDATE && !w_wp16[w_ridx]);
   assign w_deny  = chk_valid && !w_allow;
   // W1C applies before a same-cycle deny is considered
   assign w_vkeep = r_vvalid && !(w_vstat_wr && wr_data[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_allow <= 1'b0;
         chk_deny  <= 1'b0;
         r_vvalid  <= 1'b0;
         r_vaddr   <= '0;
         r_vreg    <= '0;
      end else begin
         chk_allow <= chk_valid && w_allow;
         chk_deny  <= w_deny;
         r_vvalid  <= w_vkeep || w_deny;
         if (w_deny && !w_vkeep) begin
            r_vaddr <= chk_addr;
            r_vreg  <= w_ridx;
         end
      end
   end

   assign update_en_o = (r_state == UPDATE);
   assign wp_o        = r_wp;
   assign viol_irq    = r_vvalid;

   always_comb begin
      rd_data = '0;
      if (rd_idx == 6'(IDX_CTRL))
         rd_data = {13'd0, r_state, update_en_o, w_wp16};
      if (rd_idx == 6'(IDX_VADDR))
         rd_data = 32'(r_vaddr);
      if (rd_idx == 6'(IDX_VSTAT))
         rd_data = {20'd0, r_vreg, 7'd0, r_vvalid};
      if (rd_idx == 6'(IDX_TMR))
         rd_data = 32'(w_tmr);
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (rd_idx == 6'(IDX_BASE0 + 2 * i))
            rd_data = 32'(r_base[i]);
         if (rd_idx == 6'(IDX_BASE0 + 2 * i + 1))
            rd_data = 32'(r_limit[i]);
      end
   end

endmodule

// File: tb/tb_code_sec_ctrl_mr.sv
// tb_code_sec_ctrl_mr: directed bench for code_sec_ctrl_mr
// with a queue scoreboard on the check pipeline.
module tb_code_sec_ctrl_mr;

   logic        clk;
   logic        rst_n;
   logic        lock_i;
   logic        wr_en;
   logic [5:0]  wr_idx;
   logic [31:0] wr_data;
   logic [5:0]  rd_idx;
   logic [31:0] rd_data;
   logic        chk_valid;
   logic [31:0] chk_addr;
   logic        chk_allow;
   logic        chk_deny;
   logic        update_en_o;
   logic [3:0]  wp_o;
   logic        viol_irq;

   int n_vec = 0;
   int n_err = 0;
   logic exp_q[$];

   code_sec_ctrl_mr #(
      .NUM_REGIONS    (4),
      .ADDR_W         (32),
      .TIMEOUT_W      (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lock_i      (lock_i),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
      .chk_valid   (chk_valid),
      .chk_addr    (chk_addr),
      .chk_allow   (chk_allow),
      .chk_deny    (chk_deny),
      .update_en_o (update_en_o),
      .wp_o        (wp_o),
      .viol_irq    (viol_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] idx,
                     input logic [31:0] d);
      wr_en   = 1'b1;
      wr_idx  = idx;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input string tag,
                     input logic [5:0] idx,
                     input logic [31:0] exp);
      rd_idx = idx;
      #1;
      check(tag, rd_data, exp);
   endtask

   // issue one attempt; expected outcome queued, compared on output
   task automatic chk(input string tag,
                      input logic [31:0] a,
                      input logic allow);
      logic e;
      exp_q.push_back(allow);
      chk_valid = 1'b1;
      chk_addr  = a;
      tick();
      chk_valid = 1'b0;
      e = exp_q.pop_front();
      check(tag, {30'd0, chk_allow, chk_deny}, {30'd0, e, !e});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      check("rst_out",
            {24'd0, chk_allow, chk_deny, update_en_o,
             viol_irq, wp_o},
            32'd0);
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      lock_i    = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_data   = '0;
      rd_idx    = '0;
      chk_valid = 1'b0;
      chk_addr  = '0;
      do_reset();

      rd("ctrl_rst", 6'd0, 32'h0);
      rd("tmr_rst", 6'd3, 32'h0);
      chk("no_region", 32'h100, 1'b1);

      wr(6'd4, 32'h1000);
      wr(6'd5, 32'h1FFF);
      wr(6'd6, 32'h1800);
      wr(6'd7, 32'h27FF);
      rd("base0", 6'd4, 32'h1000);
      rd("limit1", 6'd7, 32'h27FF);
      chk("open_deny", 32'h1900, 1'b0);
      rd("vaddr_open", 6'd1, 32'h1900);
      wr(6'd2, 32'h1);
      check("irq_w1c0", {31'd0, viol_irq}, 32'd0);

      wr(6'd0, 32'h2);
      check("wp1", {28'd0, wp_o}, 32'h2);
      wr(6'd0, 32'h1_0000);
      check("upd_on", {31'd0, update_en_o}, 32'd1);
      chk("overlap", 32'h1800, 1'b1);
      chk("outside", 32'h3000, 1'b1);
      chk("r1_wp", 32'h2000, 1'b0);
      rd("vaddr_r1", 6'd1, 32'h2000);
      rd("vstat_r1", 6'd2, 32'h101);
      wr(6'd2, 32'h1);
      check("irq_clr", {31'd0, viol_irq}, 32'd0);

      wr(6'd0, 32'h1);
      chk("r0_wp", 32'h1800, 1'b0);
      rd("vaddr_r0", 6'd1, 32'h1800);
      rd("vstat_r0", 6'd2, 32'h1);
      check("irq_set", {31'd0, viol_irq}, 32'd1);
      rd("ctrl_upd", 6'd0, 32'h0003_0003);

      wr(6'd0, 32'h3_0000);
      check("clr_wins", {31'd0, update_en_o}, 32'd0);

      lock_i = 1'b1;
      wr(6'd0, 32'h1_0000);
      lock_i = 1'b0;
      check("seal_upd", {31'd0, update_en_o}, 32'd0);
      rd("ctrl_seal", 6'd0, 32'h0004_0003);
      wr(6'd4, 32'h5000);
      rd("base0_lock", 6'd4, 32'h1000);
      wr(6'd0, 32'h1_0000);
      check("set_ignored", {31'd0, update_en_o}, 32'd0);

      wr(6'd2, 32'h1);
      chk("deny_a", 32'h1004, 1'b0);
      chk("deny_b", 32'h1008, 1'b0);
      rd("first_kept", 6'd1, 32'h1004);
      wr_en   = 1'b1;
      wr_idx  = 6'd2;
      wr_data = 32'h1;
      chk("deny_w1c", 32'h1010, 1'b0);
      wr_en = 1'b0;
      rd("w1c_capture", 6'd1, 32'h1010);
      check("irq_again", {31'd0, viol_irq}, 32'd1);
      wr(6'd2, 32'h1);
      check("irq_off", {31'd0, viol_irq}, 32'd0);
      chk("deny_c", 32'h1020, 1'b0);
      rd("new_capture", 6'd1, 32'h1020);

      wr(6'd0, 32'h4);
      check("wp_sealed", {28'd0, wp_o}, 32'h7);
      wr(6'd12, 32'hFFFF);
      rd("unmapped12", 6'd12, 32'h0);
      rd("unmapped40", 6'd40, 32'h0);

`ifdef CODE_SEC_TIMEOUT_EN
      do_reset();
      wr(6'd0, 32'h1_0000);
      rd("tmr_load", 6'd3, 32'd8);
      for (int i = 1; i < 8; i++) tick();
      check("to_hold", {31'd0, update_en_o}, 32'd1);
      tick();
      check("to_drop", {31'd0, update_en_o}, 32'd0);

      wr(6'd0, 32'h1_0000);
      for (int i = 1; i < 5; i++) tick();
      wr(6'd0, 32'h1_0000);
      for (int i = 6; i < 13; i++) tick();
      check("rearm_hold", {31'd0, update_en_o}, 32'd1);
      tick();
      check("rearm_drop", {31'd0, update_en_o}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
